// File: rtl/svrender_pkg.sv
// Fixed-point conventions shared across the render pipeline.
// Components are signed two's complement with FRAC_W fractional bits.
package svrender;

   localparam int DATA_W = 27;
   localparam int FRAC_W = 16;

   typedef logic signed [DATA_W-1:0] comp_t;
   typedef comp_t vec3_t [3];

endpackage

// File: rtl/sat_clamp.sv
// Narrows a wide signed value to OUT_W bits.
// Out-of-range values clamp to the nearest representable extreme.
module sat_clamp #(
   parameter int IN_W  = 55,
   parameter int OUT_W = 27
) (
   input  logic signed [IN_W-1:0]  val_i,
   output logic signed [OUT_W-1:0] val_o,
   output logic                    sat_o
);

   localparam int HEAD_W = IN_W - OUT_W + 1;

   // In range exactly when every bit above the kept sign bit repeats the sign.
   logic [HEAD_W-1:0] head;
   assign head = val_i[IN_W-1:OUT_W-1];

   always_comb begin
      // NOTE: defaults first so every path assigns every output (no latch).
      val_o = val_i[OUT_W-1:0];
      sat_o = 1'b0;
      if (head != {HEAD_W{val_i[IN_W-1]}}) begin
         sat_o = 1'b1;
         val_o = val_i[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                               : {1'b0, {(OUT_W-1){1'b1}}};
      end
   end

endmodule

// File: rtl/intersect_hit_point.sv
// Three-stage hit point pipeline: point = origin + dir * t, saturated.
// Stages S1 capture, S2 multiply, S3 add/clamp/output; all shift together.
module intersect_hit_point #(
   parameter int DATA_W = svrender::DATA_W,
   parameter int FRAC_W = svrender::FRAC_W,
   parameter int CNT_W  = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] in_origin [3],
   input  logic signed [DATA_W-1:0] in_dir [3],
   input  logic signed [DATA_W-1:0] in_t,
   input  logic                     in_hit,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [DATA_W-1:0] out_point [3],
   output logic                     out_hit,
   output logic                     out_sat,
   output logic [CNT_W-1:0]         hit_count
);

   localparam int PROD_W = 2 * DATA_W;
   // One guard bit over the product width covers origin + shifted product.
   localparam int SUM_W  = PROD_W + 1;

   logic                     enable;
   logic                     s1_valid_q, s1_hit_q;
   logic signed [DATA_W-1:0] s1_origin_q [3];
   logic signed [DATA_W-1:0] s1_dir_q [3];
   logic signed [DATA_W-1:0] s1_t_q;
   logic                     s2_valid_q, s2_hit_q, s2_live;
   logic signed [DATA_W-1:0] s2_origin_q [3];
   logic signed [PROD_W-1:0] s2_prod_q [3];
   logic                     s3_valid_q, s3_hit_q, s3_sat_q;
   logic signed [DATA_W-1:0] s3_point_q [3];
   logic [CNT_W-1:0]         hit_count_q;

   logic signed [PROD_W-1:0] prod_shr [3];
   logic signed [SUM_W-1:0]  sum [3];
   logic signed [DATA_W-1:0] clamp_val [3];
   logic [2:0]               clamp_sat;

   assign enable   = !s3_valid_q || out_ready;
   assign in_ready = enable;
   assign s2_live  = s2_valid_q && s2_hit_q;

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         prod_shr[i] = (PROD_W'(s1_dir_q[i]) * PROD_W'(s1_t_q)) >>> FRAC_W;
         sum[i]      = SUM_W'(s2_origin_q[i]) + SUM_W'(s2_prod_q[i]);
      end
   end

   for (genvar i = 0; i < 3; i++) begin : g_clamp
      sat_clamp #(
         .IN_W (SUM_W),
         .OUT_W(DATA_W)
      ) u_sat_clamp (
         .val_i(sum[i]),
         .val_o(clamp_val[i]),
         .sat_o(clamp_sat[i])
      );
   end

   // NOTE: payload registers carry no reset; only valid/output state needs a known value.
   always_ff @(posedge clk) begin
      if (enable) begin
         s1_origin_q <= in_origin;
         s1_dir_q    <= in_dir;
         s1_t_q      <= in_t;
         s1_hit_q    <= in_hit && !in_t[DATA_W-1];
         s2_origin_q <= s1_origin_q;
         s2_prod_q   <= prod_shr;
         s2_hit_q    <= s1_hit_q;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s2_valid_q  <= 1'b0;
         s3_valid_q  <= 1'b0;
         s3_hit_q    <= 1'b0;
         s3_sat_q    <= 1'b0;
         s3_point_q  <= '{default: '0};
         hit_count_q <= '0;
      end else begin
         if (enable) begin
            s1_valid_q <= in_valid;
            s2_valid_q <= s1_valid_q;
            s3_valid_q <= s2_valid_q;
            s3_hit_q   <= s2_live;
            s3_sat_q   <= s2_live && (|clamp_sat);
            for (int i = 0; i < 3; i++) begin
               s3_point_q[i] <= s2_live ? clamp_val[i] : '0;
            end
         end
         if (s3_valid_q && out_ready && s3_hit_q && (hit_count_q != '1)) begin
            hit_count_q <= hit_count_q + CNT_W'(1);
         end
      end
   end

   assign out_valid = s3_valid_q;
   assign out_point = s3_point_q;
   assign out_hit   = s3_hit_q;
   assign out_sat   = s3_sat_q;
   assign hit_count = hit_count_q;

endmodule

// File: tb/tb_intersect_hit_point.sv
// Randomized self-checking bench for intersect_hit_point against an arithmetic model.
// A second instance with a 4-bit counter exercises counter saturation.
module tb_intersect_hit_point;
   import svrender::*;

   localparam longint ONE = longint'(1) << FRAC_W;
   localparam longint HI  = (longint'(1) << (DATA_W - 1)) - 1;
   localparam longint LO  = -(longint'(1) << (DATA_W - 1));

   typedef struct {
      longint p0;
      longint p1;
      longint p2;
      bit     hit;
      bit     sat;
   } exp_t;

   logic        clk, rst, in_valid, in_hit, out_ready;
   vec3_t       in_origin, in_dir;
   comp_t       in_t;
   logic        in_ready, out_valid, out_hit, out_sat;
   vec3_t       out_point;
   logic [15:0] hit_count;
   logic        in_ready4, out_valid4, out_hit4, out_sat4;
   vec3_t       out_point4;
   logic [3:0]  hit_count4;

   intersect_hit_point dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_origin(in_origin), .in_dir(in_dir), .in_t(in_t), .in_hit(in_hit),
      .out_valid(out_valid), .out_ready(out_ready), .out_point(out_point),
      .out_hit(out_hit), .out_sat(out_sat), .hit_count(hit_count)
   );

   intersect_hit_point #(.CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
      .in_origin(in_origin), .in_dir(in_dir), .in_t(in_t), .in_hit(in_hit),
      .out_valid(out_valid4), .out_ready(out_ready), .out_point(out_point4),
      .out_hit(out_hit4), .out_sat(out_sat4), .hit_count(hit_count4)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int     n_checks = 0;
   int     n_pass   = 0;
   exp_t   q [$];
   longint hits_delivered = 0;
   bit     mon_en = 0, prev_stall = 0, prev_rst = 1, saw_not_ready = 0;
   vec3_t  prev_point;
   logic   prev_hit, prev_sat;
   int     ready_mode = 0;
   int     cyc = 0, stall_base = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, $signed(act), $signed(exp));
   endtask

   function automatic longint lmin(longint a, longint b);
      return (a < b) ? a : b;
   endfunction

   // Floor of p / 2^FRAC_W, rounding toward minus infinity.
   function automatic longint floor_frac(longint p);
      longint r = p / ONE;
      if (p < 0 && r * ONE != p) r = r - 1;
      return r;
   endfunction

   function automatic longint hit_comp(longint o, longint d, longint t, output bit s);
      longint v = o + floor_frac(d * t);
      s = 1'b0;
      if (v > HI) begin v = HI; s = 1'b1; end
      else if (v < LO) begin v = LO; s = 1'b1; end
      return v;
   endfunction

   function automatic exp_t model(vec3_t o, vec3_t d, comp_t t, logic h);
      exp_t e;
      bit s0, s1, s2;
      e = '{default: 0};
      if (h && t >= 0) begin
         e.hit = 1'b1;
         e.p0  = hit_comp(longint'(o[0]), longint'(d[0]), longint'(t), s0);
         e.p1  = hit_comp(longint'(o[1]), longint'(d[1]), longint'(t), s1);
         e.p2  = hit_comp(longint'(o[2]), longint'(d[2]), longint'(t), s2);
         e.sat = s0 | s1 | s2;
      end
      return e;
   endfunction

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         case (ready_mode)
            1:       out_ready = ($urandom_range(0, 3) != 0);
            2:       out_ready = 1'b0;
            3:       out_ready = !((cyc - stall_base) >= 2 && (cyc - stall_base) <= 8);
            default: out_ready = 1'b1;
         endcase
      end
   end

   // Monitor: samples on the falling edge, scores transfers and invariants.
   initial begin
      exp_t   e;
      longint ep [3];
      forever begin
         @(negedge clk);
         if (mon_en) begin
            check("in_ready", in_ready, !out_valid || out_ready);
            if (!in_ready) saw_not_ready = 1'b1;
            check("hit_count", hit_count, lmin(hits_delivered, 65535));
            check("hit_count4", hit_count4, lmin(hits_delivered, 15));
            if (prev_stall && !prev_rst) begin
               check("stall_valid", out_valid, 1);
               check("stall_hit", out_hit, prev_hit);
               check("stall_sat", out_sat, prev_sat);
               for (int i = 0; i < 3; i++) check($sformatf("stall_point%0d", i), out_point[i], prev_point[i]);
            end
            if (rst) begin
               q.delete();
               hits_delivered = 0;
            end else begin
               if (out_valid && out_ready) begin
                  if (q.size() == 0) begin
                     check("unexpected_output", 1, 0);
                  end else begin
                     e  = q.pop_front();
                     ep = '{e.p0, e.p1, e.p2};
                     for (int i = 0; i < 3; i++) begin
                        check($sformatf("point%0d", i), out_point[i], ep[i]);
                        check($sformatf("point4_%0d", i), out_point4[i], ep[i]);
                     end
                     check("out_hit", out_hit, e.hit);
                     check("out_sat", out_sat, e.sat);
                     check("out_valid4", out_valid4, 1);
                     check("out_hit4", out_hit4, e.hit);
                     check("out_sat4", out_sat4, e.sat);
                     if (e.hit) hits_delivered++;
                  end
               end
               if (in_valid && in_ready) q.push_back(model(in_origin, in_dir, in_t, in_hit));
            end
            prev_stall = out_valid && !out_ready;
            prev_rst   = rst;
            prev_point = out_point;
            prev_hit   = out_hit;
            prev_sat   = out_sat;
         end
      end
   end

   task automatic send(input vec3_t o, input vec3_t d, input comp_t t, input logic h);
      bit acc = 1'b0;
      in_origin = o;
      in_dir    = d;
      in_t      = t;
      in_hit    = h;
      in_valid  = 1'b1;
      for (int n = 0; n < 200 && !acc; n++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
      end
      if (!acc) check("send_timeout", 0, 1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain", q.size(), 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic expect_head(input string tag, input longint x, input bit sat);
      bit seen = 1'b0;
      for (int n = 0; n < 10 && !seen; n++) begin
         @(negedge clk);
         seen = out_valid;
      end
      check({tag, "_valid"}, seen, 1);
      check({tag, "_x"}, out_point[0], x);
      check({tag, "_sat"}, out_sat, sat);
   endtask

   function automatic comp_t rnd_mag(int mag);
      return comp_t'(int'($urandom_range(0, 2 * mag)) - mag);
   endfunction

   function automatic comp_t rnd_full();
      logic [DATA_W-1:0] r = DATA_W'($urandom);
      return comp_t'(r);
   endfunction

   initial begin
      vec3_t       o, d;
      comp_t       t;
      logic        h;
      logic [15:0] hc;
      int          n_seen;

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_hit    = 1'b0;
      in_t      = '0;
      in_origin = '{default: '0};
      in_dir    = '{default: '0};
      repeat (3) @(posedge clk);
      #1;
      rst    = 1'b0;
      mon_en = 1'b1;

      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_hit", out_hit, 0);
      check("rst_out_sat", out_sat, 0);
      for (int i = 0; i < 3; i++) check($sformatf("rst_point%0d", i), out_point[i], 0);
      check("rst_in_ready", in_ready, 1);
      @(posedge clk);
      #1;

      // Basic hit with first-result latency.
      send('{0, 0, 0}, '{65536, 0, -65536}, 131072, 1'b1);
      @(negedge clk);
      @(negedge clk);
      check("lat_k1_valid", out_valid, 0);
      @(negedge clk);
      check("lat_k2_valid", out_valid, 1);
      check("basic_x", out_point[0], 131072);
      check("basic_y", out_point[1], 0);
      check("basic_z", out_point[2], -131072);
      check("basic_hit", out_hit, 1);
      check("basic_sat", out_sat, 0);
      drain();

      // Negative t is a delivered miss.
      hc = hit_count;
      send('{5, 6, 7}, '{65536, 65536, 65536}, -65536, 1'b1);
      drain();
      check("miss_count", hit_count, hc);

      // Clamp at both extremes.
      send('{67108863, 0, 0}, '{65536, 0, 0}, 65536, 1'b1);
      expect_head("sat_hi", 67108863, 1'b1);
      drain();
      send('{-67108864, 0, 0}, '{-65536, 0, 0}, 65536, 1'b1);
      expect_head("sat_lo", -67108864, 1'b1);
      drain();

      // Random traffic with random backpressure.
      ready_mode = 1;
      for (int n = 0; n < 150; n++) begin
         case ($urandom_range(0, 3))
            0: begin
               for (int i = 0; i < 3; i++) begin o[i] = rnd_full(); d[i] = rnd_full(); end
               t = rnd_full();
            end
            1: begin
               for (int i = 0; i < 3; i++) begin o[i] = rnd_mag(1 << 20); d[i] = rnd_mag(1 << 18); end
               t = comp_t'($urandom_range(0, 1 << 18));
            end
            2: begin
               for (int i = 0; i < 3; i++) begin
                  o[i] = ($urandom_range(0, 1) != 0) ? comp_t'(HI - $urandom_range(0, 4096))
                                                     : comp_t'(LO + $urandom_range(0, 4096));
                  d[i] = rnd_mag(1 << 17);
               end
               t = comp_t'($urandom_range(0, 1 << 17));
            end
            default: begin
               for (int i = 0; i < 3; i++) begin o[i] = rnd_mag(1 << 22); d[i] = rnd_mag(1 << 18); end
               t = ($urandom_range(0, 1) != 0) ? comp_t'(0) : rnd_mag(1 << 18);
            end
         endcase
         h = ($urandom_range(0, 7) != 0);
         send(o, d, t, h);
      end
      ready_mode = 0;
      drain();

      // Six hits into a downstream stall window.
      saw_not_ready = 1'b0;
      stall_base    = cyc;
      ready_mode    = 3;
      for (int n = 0; n < 6; n++) begin
         send('{n * 100, -n * 7, 3}, '{65536, 131072, -65536}, comp_t'(65536 * (n + 1)), 1'b1);
      end
      drain();
      ready_mode = 0;
      check("stall_in_ready_drop", saw_not_ready, 1);

      // Reset with three transactions in flight.
      ready_mode = 2;
      @(posedge clk);
      #1;
      for (int n = 0; n < 3; n++) send('{n, n, n}, '{65536, 65536, 65536}, 65536, 1'b1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("flush_out_valid", out_valid, 0);
      check("flush_hit_count", hit_count, 0);
      check("flush_in_ready", in_ready, 1);
      ready_mode = 0;
      n_seen     = 0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid) n_seen++;
      end
      check("flush_none_delivered", n_seen, 0);
      @(posedge clk);
      #1;

      // Twenty hits: 16-bit counter reaches 20, 4-bit counter stops at 15.
      for (int n = 0; n < 20; n++) send('{n, 0, 0}, '{65536, 0, 0}, 65536, 1'b1);
      drain();
      check("cnt16_after_20", hit_count, 20);
      check("cnt4_saturated", hit_count4, 15);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached, got %0d passed of %0d", n_pass, n_checks);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/intersect_hit_point.md
INTERSECT_HIT_POINT -- requirements
Module: intersect_hit_point

Interface
REQ-001 Parameter DATA_W, default 27, width of each signed fixed-point vector component and of t.
REQ-002 Parameter FRAC_W, default 16, fractional bits of the fixed-point format (1.0 = 2^FRAC_W).
REQ-003 Parameter CNT_W, default 16, width of the hit counter.
REQ-004 Port clk  in  1  sole clock; all state updates on rising edge.
REQ-005 Port rst  in  1  reset, synchronous, active-high.
REQ-006 Port in_valid  in  1  input transaction present.
REQ-007 Port in_ready  out  1  block accepts input this cycle.
REQ-008 Port in_origin  in  signed [DATA_W-1:0] x3  ray origin (x,y,z), already delay-aligned with t.
REQ-009 Port in_dir  in  signed [DATA_W-1:0] x3  ray direction (x,y,z).
REQ-010 Port in_t  in  signed DATA_W  ray parameter at intersection.
REQ-011 Port in_hit  in  1  intersection unit reports a hit.
REQ-012 Port out_valid  out  1  result present.
REQ-013 Port out_ready  in  1  consumer accepts result.
REQ-014 Port out_point  out  signed [DATA_W-1:0] x3  hit point (x,y,z).
REQ-015 Port out_hit  out  1  qualified hit.
REQ-016 Port out_sat  out  1  any component of out_point was clamped.
REQ-017 Port hit_count  out  CNT_W  number of qualified hits delivered since reset.

Function
REQ-018 Transfer occurs on an edge where valid and ready are both high, independently on each side.
REQ-019 Three register stages S1 (capture), S2 (multiply), S3 (add/saturate/output); outputs driven only from S3.
REQ-020 Transaction accepted at edge k appears on outputs with out_valid=1 after edge k+2 when no stall.
REQ-021 Pipeline advance enable = !S3.valid || out_ready; all stages shift together on enable; in_ready = enable (combinational, no in_valid dependency).
REQ-022 When enable is low, every stage holds its contents; no transaction is lost, duplicated or reordered.
REQ-023 Bubbles (stage valid=0) are propagated and overwritten; they never produce out_valid.
REQ-024 Qualified hit = in_hit && in_t >= 0; negative t is a miss.
REQ-025 S2: per component, full-precision signed product dir*t (2*DATA_W bits), then arithmetic shift right by FRAC_W (truncation toward minus infinity).
REQ-026 S3: sign-extend origin, add shifted product at DATA_W+FRAC_W+1 bits minimum, clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-027 out_sat = OR over the three components of clamp engaged; out_sat is 0 for misses.
REQ-028 For misses out_point = (0,0,0), out_hit = 0, out_valid still asserted (miss is a delivered transaction).
REQ-029 hit_count increments by 1 on each output transfer with out_hit=1; saturates at 2^CNT_W-1, no wrap.
REQ-030 out_point, out_hit, out_sat remain stable while out_valid=1 and out_ready=0.

Reset
REQ-031 rst high at an edge clears all stage valid bits and hit_count; out_valid=0, out_hit=0, out_sat=0, out_point=0 from the following cycle.
REQ-032 rst during a stall or mid-stream discards all in-flight transactions; no output transfer completes on the reset edge.
REQ-033 in_ready is 1 in the first cycle after reset release.

Structure
REQ-034 DATA_W, FRAC_W defaults and typedef vec3_t (signed [DATA_W-1:0] x3) live in the shared svrender package.
REQ-035 Saturating narrow-to-DATA_W logic is one sub-module, sat_clamp, instantiated three times.

Verification
REQ-036 origin (0,0,0), dir (65536,0,-65536), t 131072, hit=1, out_ready=1 -> after 3 edges point (131072,0,-131072), out_hit=1, out_sat=0.
REQ-037 in_hit=1, t=-65536 -> out_valid=1, out_hit=0, point (0,0,0), hit_count unchanged.
REQ-038 origin x 67108863, dir x 65536, t 65536 -> point x 67108863, out_sat=1; origin x -67108864, dir x -65536 -> x -67108864, out_sat=1.
REQ-039 Stream 6 hits, out_ready low cycles 2-8 -> in_ready drops once S1..S3 full, all 6 delivered in order, outputs stable during stall.
REQ-040 rst asserted with 3 transactions in flight -> next cycle out_valid=0, hit_count=0, none of them ever delivered.
REQ-041 CNT_W=4, 20 hits delivered -> hit_count stops at 15.
